// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-unit FSM encoding and PC defaults.
package rv32i_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } ifu_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int PC_STEP_DEF = 4;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with redirect load, step up/down and reset value.
module pc_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic        ifu_clk,
  input  logic        ifu_rst_n,
  input  logic        load_en,
  input  logic [31:0] load_val,
  input  logic        count,
  input  logic        dir,
  output logic [31:0] pc
);
  always_ff @(posedge ifu_clk)
    if (!ifu_rst_n) pc <= RESET_PC;
    else if (load_en) pc <= load_val;
    else if (count) pc <= dir ? pc - 32'(PC_STEP) : pc + 32'(PC_STEP);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch FSM with IR and PC.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic        ifu_clk,
  input  logic        ifu_rst_n,
  input  logic        ir_wr_en,
  input  logic        ic_count,
  input  logic        ic_dir,
  input  logic        pc_load_en,
  input  logic [31:0] pc_load_val,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic [31:0] pc_out,
  output logic        misalign_err
);
  ifu_state_e state;
  logic [31:0] fetch_addr;
  logic load_ok;
  logic [31:0] load_val;
`ifdef IFU_MISALIGN_TRAP_EN
  logic mis;
  assign mis = pc_load_en && |pc_load_val[1:0];
  assign load_ok = pc_load_en && !mis;
  assign load_val = pc_load_val;
  always_ff @(posedge ifu_clk)
    if (!ifu_rst_n) misalign_err <= 1'b0;
    else if (mis) misalign_err <= 1'b1;
`else
  assign load_ok = pc_load_en;
  assign load_val = pc_load_val & ~32'h3;
  assign misalign_err = 1'b0;
`endif
  pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .ifu_clk(ifu_clk),
    .ifu_rst_n(ifu_rst_n),
    .load_en(load_ok),
    .load_val(load_val),
    .count(ic_count),
    .dir(ic_dir),
    .pc(pc_out)
  );
  assign mem_req = state != IDLE;
  assign fetch_busy = state != IDLE;
  assign mem_addr = fetch_addr;
  // a redirect while a read is in flight lets the read finish but drops its data
  always_ff @(posedge ifu_clk)
    if (!ifu_rst_n) begin
      state <= IDLE;
      fetch_addr <= '0;
      instr_out <= '0;
      instr_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (ir_wr_en) begin
            state <= REQ;
            fetch_addr <= pc_out;
            instr_valid <= 1'b0;
          end
        REQ:
          if (mem_ack) begin
            state <= IDLE;
            if (!load_ok) begin
              instr_out <= mem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (load_ok) state <= DISCARD;
        DISCARD: if (mem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks against a transaction-level model.
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ir_wr_en = 0, ic_count = 0, ic_dir = 0, pc_load_en = 0, mem_ack = 0;
  logic [31:0] pc_load_val = 0, mem_rdata = 0;
  logic mem_req, instr_valid, fetch_busy, misalign_err;
  logic [31:0] mem_addr, instr_out, pc_out;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_addr, m_instr;
  bit m_valid, m_busy, m_drop, m_err;

  instr_fetch_unit dut (
    .ifu_clk(clk), .ifu_rst_n(rst_n), .ir_wr_en(ir_wr_en), .ic_count(ic_count),
    .ic_dir(ic_dir), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .pc_out(pc_out), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ir_wr_en = 0; ic_count = 0; ic_dir = 0; pc_load_en = 0; mem_ack = 0;
  endtask

  task automatic step();
    bit mis, lok;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 32'h0; m_addr = 0; m_instr = 0; m_valid = 0; m_busy = 0; m_drop = 0; m_err = 0;
    end else begin
`ifdef IFU_MISALIGN_TRAP_EN
      mis = pc_load_en && (pc_load_val % 4 != 0);
`else
      mis = 0;
`endif
      lok = pc_load_en && !mis;
      if (mis) m_err = 1;
      if (!m_busy) begin
        if (ir_wr_en) begin m_busy = 1; m_drop = 0; m_addr = m_pc; m_valid = 0; end
      end else begin
        if (lok) m_drop = 1;
        if (mem_ack) begin
          m_busy = 0;
          if (!m_drop) begin m_instr = mem_rdata; m_valid = 1; end
        end
      end
      if (lok) m_pc = pc_load_val - (pc_load_val % 4);
      else if (ic_count) m_pc = ic_dir ? m_pc - 4 : m_pc + 4;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); step(); step(); rst_n = 1;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
    checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_req got %b%b want 00", mem_req, fetch_busy); end
    checks++; if (mem_addr !== 32'h0 || instr_out !== 32'h0) begin errors++; $display("FAIL reset_regs got %h %h want 0 0", mem_addr, instr_out); end
    checks++; if (instr_valid !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", instr_valid, misalign_err); end
  endtask

  task automatic test_basic();
    ir_wr_en = 1; ic_count = 1; step(); idle_inputs();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL basic_req got %b %h want 1 0", mem_req, mem_addr); end
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL basic_pc got %h want 4", pc_out); end
    mem_ack = 1; mem_rdata = 32'h33; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h33) begin errors++; $display("FAIL basic_instr got %b %h want 1 33", instr_valid, instr_out); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", mem_req); end
  endtask

  task automatic test_delayed_ack();
    ir_wr_en = 1; step(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL hold_%0d got %b %h want 1 4", i, mem_req, mem_addr); end
      ir_wr_en = (i == 2); ic_count = (i == 1); step(); idle_inputs();
    end
    mem_ack = 1; mem_rdata = 32'hCAFE_0013; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'hCAFE_0013) begin errors++; $display("FAIL delayed_instr got %b %h want 1 cafe0013", instr_valid, instr_out); end
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL no_queue got %b want 0", mem_req); end
  endtask

  task automatic test_discard();
    ir_wr_en = 1; step(); idle_inputs();
    pc_load_en = 1; pc_load_val = 32'h100; step(); idle_inputs();
    checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL discard_wait got %b %b want 1 0", mem_req, instr_valid); end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b0 || instr_out !== 32'hCAFE_0013 || mem_req !== 1'b0) begin errors++; $display("FAIL discard_drop got %b %h %b want 0 cafe0013 0", instr_valid, instr_out, mem_req); end
    ir_wr_en = 1; step(); idle_inputs();
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL discard_next got %h want 100", mem_addr); end
    pc_load_en = 1; pc_load_val = 32'h200; mem_ack = 1; mem_rdata = 32'h1234; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_out !== 32'h200) begin errors++; $display("FAIL discard_same got %b %b %h want 0 0 200", instr_valid, mem_req, pc_out); end
  endtask

  task automatic test_wrap();
    pc_load_en = 1; pc_load_val = 32'hFFFF_FFFC; step(); idle_inputs();
    ic_count = 1; step(); idle_inputs();
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_up got %h want 0", pc_out); end
    ic_count = 1; ic_dir = 1; step(); idle_inputs();
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_down got %h want fffffffc", pc_out); end
    pc_load_en = 1; pc_load_val = 32'h40; ic_count = 1; step(); idle_inputs();
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL load_prio got %h want 40", pc_out); end
  endtask

  task automatic test_misalign();
    pc_load_en = 1; pc_load_val = 32'h100; step(); idle_inputs();
    pc_load_en = 1; pc_load_val = 32'h102; step(); idle_inputs();
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL mis_pc got %h want 100", pc_out); end
`ifdef IFU_MISALIGN_TRAP_EN
    step();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", misalign_err); end
    ir_wr_en = 1; step(); idle_inputs();
    pc_load_en = 1; pc_load_val = 32'h303; step(); idle_inputs();
    checks++; if (mem_req !== 1'b1 || pc_out !== 32'h100) begin errors++; $display("FAIL mis_nodiscard got %b %h want 1 100", mem_req, pc_out); end
    mem_ack = 1; mem_rdata = 32'h77; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h77) begin errors++; $display("FAIL mis_keep got %b %h want 1 77", instr_valid, instr_out); end
`else
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_err got %b want 0", misalign_err); end
`endif
  endtask

  task automatic test_reset_mid();
    ir_wr_en = 1; ic_count = 1; step(); idle_inputs();
    rst_n = 0; mem_ack = 0; step(); rst_n = 1;
    checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || pc_out !== 32'h0) begin errors++; $display("FAIL rstmid got %b %b %h want 0 0 0", mem_req, fetch_busy, pc_out); end
    mem_ack = 1; mem_rdata = 32'h5555_AAAA; step(); idle_inputs();
    checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL stale_ack got %b %h %b want 0 0 0", instr_valid, instr_out, misalign_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      checks++;
      if (pc_out !== m_pc || mem_req !== m_busy || fetch_busy !== m_busy || mem_addr !== m_addr ||
          instr_valid !== m_valid || instr_out !== m_instr || misalign_err !== m_err) begin
        errors++;
        $display("FAIL rand_%0d got pc=%h req=%b busy=%b addr=%h v=%b ir=%h err=%b want pc=%h req=%b addr=%h v=%b ir=%h err=%b",
                 i, pc_out, mem_req, fetch_busy, mem_addr, instr_valid, instr_out, misalign_err,
                 m_pc, m_busy, m_addr, m_valid, m_instr, m_err);
      end
      rst_n = $urandom_range(0, 99) != 0;
      ir_wr_en = $urandom_range(0, 2) == 0;
      ic_count = $urandom_range(0, 1);
      ic_dir = $urandom_range(0, 1);
      pc_load_en = $urandom_range(0, 7) == 0;
      pc_load_val = $urandom_range(0, 3) == 0 ? $urandom : {$urandom} & ~32'h3;
      mem_ack = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
      step();
    end
    rst_n = 1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_discard();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-002 Parameter PC_STEP, default 4, byte step applied by ic_count.
REQ-003 ifu_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 ifu_rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 ir_wr_en  input  1  fetch request from control unit.
REQ-006 ic_count  input  1  advance PC by PC_STEP in the ic_dir direction.
REQ-007 ic_dir  input  1  0 = PC+PC_STEP, 1 = PC-PC_STEP.
REQ-008 pc_load_en  input  1  redirect PC (branch/jump).
REQ-009 pc_load_val  input  32  redirect target.
REQ-010 mem_req  output  1  instruction-memory read request.
REQ-011 mem_addr  output  32  read address; stable while mem_req high.
REQ-012 mem_ack  input  1  read data valid on mem_rdata this cycle.
REQ-013 mem_rdata  input  32  read data.
REQ-014 instr_out  output  32  latched instruction; feeds control unit instr_in.
REQ-015 instr_valid  output  1  instr_out holds a completed, non-discarded fetch.
REQ-016 fetch_busy  output  1  high in REQ or DISCARD.
REQ-017 pc_out  output  32  current PC.
REQ-018 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-019 FSM states: IDLE, REQ, DISCARD; 2-bit encoding.
REQ-020 IDLE + ir_wr_en: capture pc_out into fetch_addr, go REQ, clear instr_valid; mem_req high from next cycle.
REQ-021 REQ: mem_req=1, mem_addr=fetch_addr; on mem_ack, load instr_out<=mem_rdata, set instr_valid, go IDLE.
REQ-022 Latency: ir_wr_en at cycle N, ack at cycle M>=N+1 -> instr_valid high at M+1; minimum 2 cycles.
REQ-023 ir_wr_en in REQ or DISCARD is ignored; no queueing.
REQ-024 PC update independent of FSM: pc_load_en has priority over ic_count; both low -> PC holds.
REQ-025 ir_wr_en and ic_count in the same cycle: fetch_addr takes the pre-increment PC.
REQ-026 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0; 0-4 = 32'hFFFF_FFFC.
REQ-027 pc_load_en in REQ: go DISCARD; outstanding read completes, data dropped, instr_out and instr_valid unchanged (instr_valid stays 0); DISCARD + mem_ack -> IDLE.
REQ-028 pc_load_en in REQ with mem_ack same cycle: data dropped, go IDLE.
REQ-029 mem_ack in IDLE is ignored.

Reset
REQ-030 ifu_rst_n low at a rising edge: state=IDLE, PC=RESET_PC, instr_out=0, instr_valid=0, mem_req=0, mem_addr=0, misalign_err=0.
REQ-031 Reset overrides all inputs, including mid-fetch; a later mem_ack for the abandoned read is ignored.

Configuration
REQ-032 Macro IFU_MISALIGN_TRAP_EN defined: pc_load_val[1:0]!=0 on pc_load_en sets misalign_err (sticky until reset), PC unchanged, no DISCARD transition.
REQ-033 IFU_MISALIGN_TRAP_EN undefined: pc_load_val[1:0] forced to 0 on load; misalign_err tied 0.

Structure
REQ-034 Shared package rv32i_pkg holds FSM state encodings, RESET_PC default, PC_STEP default.
REQ-035 One sub-module pc_reg (PC register: load, increment/decrement, reset value); FSM and IR in the top.

Verification
REQ-036 Reset then ir_wr_en+ic_count, ack 1 cycle later with 32'h0000_0033 -> mem_addr=0, PC=4, instr_out=32'h33, instr_valid at cycle 3.
REQ-037 Ack delayed 5 cycles -> mem_req and mem_addr held stable throughout; second ir_wr_en during wait ignored.
REQ-038 pc_load_en=1, val=32'h100 during REQ -> read completes, data discarded, instr_valid=0, next fetch address 32'h100.
REQ-039 PC=32'hFFFF_FFFC, ic_count, ic_dir=0 -> PC=0; PC=0, ic_dir=1 -> 32'hFFFF_FFFC.
REQ-040 pc_load_val=32'h102 -> with macro: misalign_err=1, PC unchanged; without: PC=32'h100.
REQ-041 ifu_rst_n low mid-REQ -> next cycle IDLE, mem_req=0, PC=RESET_PC; stale ack ignored.
